// File: rtl/dgldpc_vnu_out_stage.sv
// dgldpc_vnu_out_stage: VNU result requantisation to 6-bit SM V2C messages, hard decision, skid-buffered output and per-frame HD word
// Optional macro SAT_CNT_EN adds o_sat_cnt, a per-frame count of saturated extrinsic lanes.
module dgldpc_vnu_out_stage #(
  parameter int N_COL = 16,
  parameter int SHIFT = 0,
  localparam int CW = $clog2(N_COL)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [0:4][10:0]      i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [0:3][5:0]       o_data,
  output logic                  o_hd,
  output logic [CW-1:0]         o_col,
  output logic                  o_last,
  output logic [N_COL-1:0]      o_hd_word,
  output logic                  o_hd_valid
`ifdef SAT_CNT_EN
  ,
  output logic [15:0]           o_sat_cnt
`endif
);
  logic [0:3][5:0] q_data;
  logic            q_hd;
  logic            in_fire, out_fire, blocked;
  logic [CW-1:0]   col_q, col_d;
  logic            out_valid_q, skid_full_q;
  logic [0:3][5:0] out_data_q, skid_data_q;
  logic            out_hd_q, skid_hd_q;
  logic [CW-1:0]   out_col_q, skid_col_q;
  logic [N_COL-1:0] acc_q, acc_d, hd_word_q;
  logic            hd_valid_q;
`ifdef SAT_CNT_EN
  logic [3:0]      sat;
  logic [2:0]      q_nsat, out_nsat_q, skid_nsat_q;
  logic [15:0]     sat_cnt_q;
  logic [16:0]     sat_sum;
`endif

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [9:0] m;
    logic       s;
    logic [4:0] mag;
    assign m   = i_data[l][9:0] >> SHIFT;
    assign s   = m > 10'd31;
    assign mag = s ? 5'd31 : m[4:0];
    // a zero magnitude always leaves as +0
    assign q_data[l] = {i_data[l][10] & (mag != 5'd0), mag};
`ifdef SAT_CNT_EN
    assign sat[l] = s;
`endif
  end

  assign q_hd     = i_data[4][10] & (|i_data[4][9:0]);
  assign o_ready  = ~skid_full_q;
  assign in_fire  = i_valid & ~skid_full_q;
  assign out_fire = out_valid_q & i_ready;
  assign blocked  = out_valid_q & ~i_ready;
  assign col_d    = in_fire ? ((col_q == CW'(N_COL - 1)) ? '0 : col_q + 1'b1) : col_q;
  assign o_valid  = out_valid_q;
  assign o_data   = out_data_q;
  assign o_hd     = out_hd_q;
  assign o_col    = out_col_q;
  assign o_last   = out_col_q == CW'(N_COL - 1);
  assign o_hd_word  = hd_word_q;
  assign o_hd_valid = hd_valid_q;
`ifdef SAT_CNT_EN
  assign q_nsat    = 3'(sat[0]) + 3'(sat[1]) + 3'(sat[2]) + 3'(sat[3]);
  assign sat_sum   = {1'b0, hd_valid_q ? 16'd0 : sat_cnt_q} + 17'(out_fire ? out_nsat_q : 3'd0);
  assign o_sat_cnt = sat_cnt_q;
`endif

  // column index is taken when a beat is accepted and travels with it
  always_ff @(posedge clk) begin
    if (rst) col_q <= '0;
    else col_q <= col_d;
  end

  // output register plus one-entry skid; skid only fills when the output is blocked
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_hd_q    <= 1'b0;
      out_col_q   <= '0;
      skid_full_q <= 1'b0;
      skid_data_q <= '0;
      skid_hd_q   <= 1'b0;
      skid_col_q  <= '0;
`ifdef SAT_CNT_EN
      out_nsat_q  <= '0;
      skid_nsat_q <= '0;
`endif
    end else if (skid_full_q) begin
      if (out_fire) begin
        out_data_q  <= skid_data_q;
        out_hd_q    <= skid_hd_q;
        out_col_q   <= skid_col_q;
`ifdef SAT_CNT_EN
        out_nsat_q  <= skid_nsat_q;
`endif
        skid_full_q <= 1'b0;
      end
    end else if (in_fire) begin
      if (blocked) begin
        skid_data_q <= q_data;
        skid_hd_q   <= q_hd;
        skid_col_q  <= col_q;
`ifdef SAT_CNT_EN
        skid_nsat_q <= q_nsat;
`endif
        skid_full_q <= 1'b1;
      end else begin
        out_data_q  <= q_data;
        out_hd_q    <= q_hd;
        out_col_q   <= col_q;
`ifdef SAT_CNT_EN
        out_nsat_q  <= q_nsat;
`endif
        out_valid_q <= 1'b1;
      end
    end else if (out_fire) begin
      out_valid_q <= 1'b0;
    end
  end

  // accumulator with the current output beat's decision merged in
  always_comb begin
    acc_d = acc_q;
    if (out_fire) acc_d[out_col_q] = out_hd_q;
  end

  // publish the frame word the cycle after its last column leaves
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      hd_word_q  <= '0;
      hd_valid_q <= 1'b0;
    end else begin
      hd_valid_q <= out_fire & o_last;
      if (out_fire & o_last) begin
        hd_word_q <= acc_d;
        acc_q     <= '0;
      end else begin
        acc_q <= acc_d;
      end
    end
  end

`ifdef SAT_CNT_EN
  // per-frame saturation count, restarted on the word-valid pulse
  always_ff @(posedge clk) begin
    if (rst) sat_cnt_q <= '0;
    else sat_cnt_q <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_dgldpc_vnu_out_stage.sv
// tb_dgldpc_vnu_out_stage: directed vectors and hand-written sequences for the VNU output stage
module tb_dgldpc_vnu_out_stage;
  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             i_valid = 1'b0;
  logic             i_ready = 1'b1;
  logic [0:4][10:0] i_data = '0;
  logic             o_ready, o_valid, o_hd, o_last, o_hd_valid;
  logic [0:3][5:0]  o_data;
  logic [3:0]       o_col;
  logic [15:0]      o_hd_word;
  logic             o_ready2, o_valid2, o_hd2, o_last2, o_hd_valid2;
  logic [0:3][5:0]  o_data2;
  logic [3:0]       o_col2;
  logic [15:0]      o_hd_word2;
`ifdef SAT_CNT_EN
  logic [15:0]      o_sat_cnt, o_sat_cnt2;
`endif
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dgldpc_vnu_out_stage #(.N_COL(16), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_hd(o_hd), .o_col(o_col),
    .o_last(o_last), .o_hd_word(o_hd_word), .o_hd_valid(o_hd_valid)
`ifdef SAT_CNT_EN
    , .o_sat_cnt(o_sat_cnt)
`endif
  );

  dgldpc_vnu_out_stage #(.N_COL(16), .SHIFT(2)) dut2 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready2), .i_data(i_data),
    .o_valid(o_valid2), .i_ready(i_ready), .o_data(o_data2), .o_hd(o_hd2), .o_col(o_col2),
    .o_last(o_last2), .o_hd_word(o_hd_word2), .o_hd_valid(o_hd_valid2)
`ifdef SAT_CNT_EN
    , .o_sat_cnt(o_sat_cnt2)
`endif
  );

  typedef struct packed {
    logic [0:3][10:0] lane;
    logic [10:0]      app;
    logic [0:3][5:0]  e0;
    logic [0:3][5:0]  e2;
    logic             hd;
  } vec_t;

  vec_t v [5];

  function automatic vec_t mk(logic [0:3][10:0] l, logic [10:0] a, logic [0:3][5:0] e0,
                              logic [0:3][5:0] e2, logic hd);
    mk.lane = l;
    mk.app  = a;
    mk.e0   = e0;
    mk.e2   = e2;
    mk.hd   = hd;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_data = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int sent, got;
    logic stall, low;
    logic [0:3][5:0] snap;
    logic [15:0] pat;
    v[0] = mk({11'h005, 11'h41F, 11'h020, 11'h400}, 11'h400,
              {6'h05, 6'h3F, 6'h1F, 6'h00}, {6'h01, 6'h27, 6'h08, 6'h00}, 1'b0);
    v[1] = mk({11'h47F, 11'h403, 11'h3FF, 11'h7FF}, 11'h401,
              {6'h3F, 6'h23, 6'h1F, 6'h3F}, {6'h3F, 6'h00, 6'h1F, 6'h3F}, 1'b1);
    v[2] = mk({11'h01F, 11'h41E, 11'h000, 11'h001}, 11'h200,
              {6'h1F, 6'h3E, 6'h00, 6'h01}, {6'h07, 6'h27, 6'h00, 6'h00}, 1'b0);
    v[3] = mk({11'h07C, 11'h47C, 11'h003, 11'h404}, 11'h7FF,
              {6'h1F, 6'h3F, 6'h03, 6'h24}, {6'h1F, 6'h3F, 6'h00, 6'h21}, 1'b1);
    v[4] = mk({11'h010, 11'h410, 11'h07F, 11'h080}, 11'h000,
              {6'h10, 6'h30, 6'h1F, 6'h1F}, {6'h04, 6'h24, 6'h1F, 6'h1F}, 1'b0);

    reset_dut();
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_o_hd", o_hd, 0);
    chk("rst_o_col", o_col, 0);
    chk("rst_o_last", o_last, 0);
    chk("rst_hd_word", o_hd_word, 0);
    chk("rst_hd_valid", o_hd_valid, 0);
    chk("rst_o_ready", o_ready, 1);

    for (int k = 0; k < 5; k++) begin
      i_data = {v[k].lane, v[k].app};
      i_valid = 1'b1;
      step();
      chk("q_valid", o_valid, 1);
      chk("q_data_s0", o_data, v[k].e0);
      chk("q_data_s2", o_data2, v[k].e2);
      chk("q_hd", o_hd, v[k].hd);
      chk("q_col", o_col, 32'(k));
    end
    i_valid = 1'b0;
    step();
    chk("idle_valid", o_valid, 0);

    reset_dut();
    sent = 0;
    got = 0;
    stall = 1'b0;
    low = 1'b0;
    snap = '0;
    for (int c = 0; c < 14; c++) begin
      i_valid = sent < 5;
      i_data = '0;
      i_data[0] = 11'(sent);
      i_ready = !(c >= 2 && c < 5);
      if (stall) chk("bp_hold", o_data, snap);
      stall = o_valid && !i_ready;
      snap = o_data;
      if (!o_ready) low = 1'b1;
      if (o_valid && i_ready) begin
        chk("bp_order", 32'(o_data[0]), 32'(got));
        chk("bp_col", o_col, 32'(got));
        got++;
      end
      if (i_valid && o_ready) sent++;
      step();
    end
    chk("bp_count", 32'(got), 5);
    chk("bp_ready_low", low, 1);

    reset_dut();
    pat = 16'hA5C3;
    for (int k = 0; k <= 16; k++) begin
      i_valid = 1'b1;
      i_data = '0;
      i_data[4] = {pat[k % 16], 10'd1};
      if (k == 0) i_data[0:3] = {11'h3FF, 11'h7FF, 11'h020, 11'h000};
      if (k == 9) i_data[0:3] = {11'h040, 11'h440, 11'h000, 11'h000};
      step();
      chk("fr_col", o_col, 32'(k % 16));
      chk("fr_last", o_last, 32'(k == 15));
      chk("fr_hd", o_hd, 32'(pat[k % 16]));
      if (k == 16) begin
        chk("fr_hd_valid", o_hd_valid, 1);
        chk("fr_hd_word", o_hd_word, 32'(pat));
`ifdef SAT_CNT_EN
        chk("fr_sat_cnt", o_sat_cnt, 5);
`endif
      end else begin
        chk("fr_hd_valid_low", o_hd_valid, 0);
      end
    end
    i_valid = 1'b0;
    step();
    chk("fr_pulse_end", o_hd_valid, 0);
    chk("fr_word_hold", o_hd_word, 32'(pat));
`ifdef SAT_CNT_EN
    chk("fr_sat_clear", o_sat_cnt, 0);
`endif

    reset_dut();
    for (int k = 0; k < 7; k++) begin
      i_valid = 1'b1;
      i_data = '0;
      i_data[4] = 11'h401;
      step();
    end
    rst = 1'b1;
    step();
    chk("mr_valid", o_valid, 0);
    chk("mr_col", o_col, 0);
    chk("mr_hd_word", o_hd_word, 0);
    chk("mr_hd_valid", o_hd_valid, 0);
    chk("mr_ready", o_ready, 1);
    rst = 1'b0;
    pat = 16'h0F0F;
    for (int k = 0; k < 16; k++) begin
      i_valid = 1'b1;
      i_data = '0;
      i_data[4] = {pat[k], 10'd7};
      step();
      chk("mr_last", o_last, 32'(k == 15));
      chk("mr_col_seq", o_col, 32'(k));
    end
    i_valid = 1'b0;
    step();
    chk("mr_hd_valid_pulse", o_hd_valid, 1);
    chk("mr_hd_word_new", o_hd_word, 32'(pat));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
